// File: rtl/mips_control_fsm_if.sv
// Instruction handshake bundle between the upstream fetch logic and the
// multi-cycle MIPS control unit.
interface mips_control_fsm_if;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instr_in,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_in,
        output instr_ready
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multi-cycle control unit for the MIPS datapath. Accepts one instruction
// per handshake, holds it on ir_out and sequences registered control lines
// through DECODE, EXEC, MEM and WB. Write enables are one-cycle pulses.
module mips_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    mips_control_fsm_if.slave bus,
    output logic [31:0]      ir_out,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic [3:0]       ALUCtrl,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       mem_to_reg;
    } dec_t;

    // Static decode of an instruction word; illegal words decode to all-zero controls.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t r;
        r = '0;
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h20:   begin r.legal = 1'b1; r.alu_ctrl = 4'b0010; end
                    6'h22:   begin r.legal = 1'b1; r.alu_ctrl = 4'b0110; end
                    6'h24:   begin r.legal = 1'b1; r.alu_ctrl = 4'b0000; end
                    6'h25:   begin r.legal = 1'b1; r.alu_ctrl = 4'b0001; end
                    6'h27:   begin r.legal = 1'b1; r.alu_ctrl = 4'b1100; end
                    6'h2A:   begin r.legal = 1'b1; r.alu_ctrl = 4'b0111; end
                    default: r = '0;
                endcase
            end
            6'h08: begin
                r.legal = 1'b1; r.reg_dst = 1'b1; r.alu_src = 1'b1; r.alu_ctrl = 4'b0010;
            end
            6'h23: begin
                r.legal = 1'b1; r.reg_dst = 1'b1; r.alu_src = 1'b1; r.alu_ctrl = 4'b0010;
                r.mem_to_reg = 1'b1;
            end
            6'h2B: begin
                r.legal = 1'b1; r.alu_src = 1'b1; r.alu_ctrl = 4'b0010;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic               reg_dst_q, reg_dst_d;
    logic               alu_src_q, alu_src_d;
    logic [3:0]         alu_ctrl_q, alu_ctrl_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               reg_write_q, reg_write_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   count_q, count_d;
    dec_t               dec_s;
    logic               is_lw_s;
    logic               is_sw_s;

    // Next-state and next-output logic; every control output is registered from here.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        reg_dst_d    = reg_dst_q;
        alu_src_d    = alu_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        dec_s        = decode(bus.instr_in);
        is_lw_s      = (ir_q[31:26] == 6'h23);
        is_sw_s      = (ir_q[31:26] == 6'h2B);

        // The counter steps on the edge that closes the done cycle.
        if (done_q) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.instr_valid && ready_q) begin
                    ir_d         = bus.instr_in;
                    state_d      = DECODE;
                    reg_dst_d    = dec_s.reg_dst;
                    alu_src_d    = dec_s.alu_src;
                    alu_ctrl_d   = dec_s.alu_ctrl;
                    mem_to_reg_d = dec_s.mem_to_reg;
                    illegal_d    = ~dec_s.legal;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                if (illegal_q) begin
                    state_d      = IDLE;
                    reg_dst_d    = 1'b0;
                    alu_src_d    = 1'b0;
                    alu_ctrl_d   = 4'b0000;
                    mem_to_reg_d = 1'b0;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_lw_s || is_sw_s) begin
                    state_d     = MEM;
                    mem_read_d  = is_lw_s;
                    mem_write_d = is_sw_s;
                    done_d      = is_sw_s;
                end else begin
                    state_d     = WB;
                    reg_write_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            MEM: begin
                if (is_lw_s) begin
                    state_d     = WB;
                    mem_read_d  = 1'b1;
                    reg_write_d = 1'b1;
                    done_d      = 1'b1;
                end else begin
                    state_d      = IDLE;
                    reg_dst_d    = 1'b0;
                    alu_src_d    = 1'b0;
                    alu_ctrl_d   = 4'b0000;
                    mem_to_reg_d = 1'b0;
                end
            end
            WB: begin
                state_d      = IDLE;
                reg_dst_d    = 1'b0;
                alu_src_d    = 1'b0;
                alu_ctrl_d   = 4'b0000;
                mem_to_reg_d = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                reg_dst_d    = 1'b0;
                alu_src_d    = 1'b0;
                alu_ctrl_d   = 4'b0000;
                mem_to_reg_d = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset that also drops any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ir_q         <= 32'h0000_0000;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= 4'b0000;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            ready_q      <= 1'b1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
            ready_q      <= ready_d;
            count_q      <= count_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign ir_out          = ir_q;
    assign RegDst          = reg_dst_q;
    assign ALUSrc          = alu_src_q;
    assign ALUCtrl         = alu_ctrl_q;
    assign MemRead         = mem_read_q;
    assign MemWrite        = mem_write_q;
    assign MemtoReg        = mem_to_reg_q;
    assign RegWrite        = reg_write_q;
    assign done            = done_q;
    assign illegal         = illegal_q;
    assign instr_count     = count_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed self-checking bench for mips_control_fsm. Control outputs are
// packed as {ready, RegDst, ALUSrc, ALUCtrl, MemRead, MemWrite, MemtoReg,
// RegWrite, done, illegal} and compared cycle by cycle against hand tables.
module tb_mips_control_fsm;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      ir_out;
    logic             RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, done, illegal;
    logic [3:0]       ALUCtrl;
    logic [CNT_W-1:0] instr_count;

    mips_control_fsm_if bus_if();

    mips_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus_if),
        .ir_out(ir_out), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .done(done), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          exp_count = 0;
    logic [12:0] exp_tab [0:7];

    localparam logic [12:0] IDLE_V = 13'b1_0_0_0000_000000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ctl_vec();
        return {bus_if.instr_ready, RegDst, ALUSrc, ALUCtrl,
                MemRead, MemWrite, MemtoReg, RegWrite, done, illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present w for one acceptance edge; optionally keep valid high with nxt afterwards.
    task automatic issue(input logic [31:0] w, input logic hold, input logic [31:0] nxt);
        bus_if.instr_valid = 1'b1;
        bus_if.instr_in    = w;
        step();
        if (hold) begin
            bus_if.instr_in = nxt;
        end else begin
            bus_if.instr_valid = 1'b0;
        end
    endtask

    task automatic run_checked(input string tag, input logic [31:0] w, input int n,
                               input logic hold, input logic [31:0] nxt);
        issue(w, hold, nxt);
        check_eq({tag, " ir_out"}, ir_out, w);
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            check_eq($sformatf("%s c%0d", tag, k + 1), 32'(ctl_vec()), 32'(exp_tab[k]));
        end
    endtask

    // Table for a four-cycle register-writing instruction (R-type or ADDI).
    task automatic set_reg_tab(input logic rd, input logic as, input logic [3:0] alu);
        exp_tab[0] = {1'b0, rd, as, alu, 6'b000000};
        exp_tab[1] = {1'b0, rd, as, alu, 6'b000000};
        exp_tab[2] = {1'b0, rd, as, alu, 6'b000110};
        exp_tab[3] = IDLE_V;
    endtask

    task automatic set_lw_tab();
        exp_tab[0] = 13'b0_1_1_0010_001000;
        exp_tab[1] = 13'b0_1_1_0010_001000;
        exp_tab[2] = 13'b0_1_1_0010_101000;
        exp_tab[3] = 13'b0_1_1_0010_101110;
        exp_tab[4] = IDLE_V;
    endtask

    task automatic check_count(input string tag);
        check_eq(tag, 32'(instr_count), 32'(exp_count));
    endtask

    logic [5:0] functs [0:5];
    logic [3:0] alus   [0:5];

    initial begin
        functs[0] = 6'h20; alus[0] = 4'b0010;
        functs[1] = 6'h22; alus[1] = 4'b0110;
        functs[2] = 6'h24; alus[2] = 4'b0000;
        functs[3] = 6'h25; alus[3] = 4'b0001;
        functs[4] = 6'h27; alus[4] = 4'b1100;
        functs[5] = 6'h2A; alus[5] = 4'b0111;

        rst                = 1'b1;
        bus_if.instr_valid = 1'b1;
        bus_if.instr_in    = 32'h012A_4020;
        repeat (3) step();
        check_eq("reset ctl", 32'(ctl_vec()), 32'(IDLE_V));
        check_eq("reset ir_out", ir_out, 32'h0000_0000);
        check_count("reset count");
        bus_if.instr_valid = 1'b0;
        rst                = 1'b0;

        // ADD
        set_reg_tab(1'b0, 1'b0, 4'b0010);
        run_checked("add", 32'h012A_4020, 4, 1'b0, 32'h0);
        exp_count++;
        check_count("add count");

        // LW then SW with valid held high throughout the LW
        set_lw_tab();
        run_checked("lw", 32'h8D09_0004, 5, 1'b1, 32'hAD09_0008);
        check_eq("lw ir held", ir_out, 32'h8D09_0004);
        exp_count++;
        check_count("lw count");
        exp_tab[0] = 13'b0_0_1_0010_000000;
        exp_tab[1] = 13'b0_0_1_0010_000000;
        exp_tab[2] = 13'b0_0_1_0010_010010;
        exp_tab[3] = IDLE_V;
        run_checked("sw", 32'hAD09_0008, 4, 1'b0, 32'h0);
        exp_count++;
        check_count("sw count");

        // All R-type functions, then ADDI
        for (int i = 0; i < 6; i++) begin
            set_reg_tab(1'b0, 1'b0, alus[i]);
            run_checked($sformatf("rtype_%0h", functs[i]),
                        {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, functs[i]}, 4, 1'b0, 32'h0);
            exp_count++;
        end
        set_reg_tab(1'b1, 1'b1, 4'b0010);
        run_checked("addi", 32'h2128_0005, 4, 1'b0, 32'h0);
        exp_count++;
        check_count("alu count");

        // Illegal opcode and illegal funct
        exp_tab[0] = 13'b0_0_0_0000_000001;
        exp_tab[1] = IDLE_V;
        run_checked("ill_op", 32'hFC00_0000, 2, 1'b0, 32'h0);
        run_checked("ill_fn", 32'h012A_4003, 2, 1'b0, 32'h0);
        check_count("ill count");

        // Reset during LW MEM state
        issue(32'h8D09_0004, 1'b0, 32'h0);
        step();
        step();
        check_eq("rst lw mem", 32'(MemRead), 32'h1);
        rst = 1'b1;
        step();
        exp_count = 0;
        check_eq("rst abort ctl", 32'(ctl_vec()), 32'(IDLE_V));
        check_count("rst abort count");
        rst = 1'b0;
        step();
        check_eq("rst after ctl", 32'(ctl_vec()), 32'(IDLE_V));
        set_reg_tab(1'b0, 1'b0, 4'b0010);
        run_checked("add2", 32'h012A_4020, 4, 1'b0, 32'h0);
        exp_count++;
        check_count("add2 count");

        // Counter wrap
        while (exp_count != (1 << CNT_W) - 1) begin
            issue(32'h2128_0005, 1'b0, 32'h0);
            repeat (3) step();
            exp_count++;
        end
        check_count("count max");
        issue(32'h2128_0005, 1'b0, 32'h0);
        repeat (3) step();
        exp_count = 0;
        check_count("count wrap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multi-cycle control unit that drives the control side of the single-cycle MIPS datapath. It accepts one 32-bit instruction per valid/ready handshake and holds it stable on `ir_out`, which feeds the datapath `instruction` input. It then sequences the datapath control lines through decode, execute, memory and writeback states. It guarantees one-cycle write pulses, because register-file and memory writes in the datapath are edge-triggered.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `instr_valid`  in  1  upstream presents an instruction on `instr_in`.
- `instr_in`  in  32  instruction word.
- `instr_ready`  out  1  high only in IDLE; a transfer occurs when `instr_valid && instr_ready` is sampled at a rising edge.
- `ir_out`  out  32  latched instruction, stable from acceptance until the next acceptance.
- `RegDst`  out  1  1 selects rt [20:16] as write register; 0 selects rd [15:11].
- `ALUSrc`  out  1  1 selects sign-extended immediate; 0 selects register operand 2.
- `ALUCtrl`  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `MemRead`  out  1  memory read enable.
- `MemWrite`  out  1  memory write pulse.
- `MemtoReg`  out  1  1 selects memory data for writeback; 0 selects ALU result.
- `RegWrite`  out  1  register-file write pulse.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse when an instruction is rejected.
- `instr_count`  out  CNT_W  count of retired legal instructions; wraps modulo 2^CNT_W.

## Operation
Supported instructions:
- R-type (opcode 0x00): funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
  - Controls: RegDst=0, ALUSrc=0, MemtoReg=0.
- ADDI (0x08): RegDst=1, ALUSrc=1, ALUCtrl=0010, MemtoReg=0.
- LW (0x23): RegDst=1, ALUSrc=1, ALUCtrl=0010, MemtoReg=1.
- SW (0x2B): ALUSrc=1, ALUCtrl=0010. RegDst and MemtoReg are don't-care and driven 0.
- Any other opcode, or opcode 0 with any other funct, is illegal.

States:
- IDLE
  - `instr_ready`=1. On handshake, latch `instr_in` into `ir_out` and go to DECODE.
- DECODE
  - Register RegDst, ALUSrc, ALUCtrl and MemtoReg from `ir_out`. These stay constant until the FSM returns to IDLE.
  - Illegal instruction: pulse `illegal`, clear all controls, go to IDLE.
  - Legal instruction: go to EXEC.
- EXEC
  - ALU settle cycle; no enables asserted.
  - LW/SW go to MEM. R-type/ADDI go to WB.
- MEM
  - LW: MemRead=1, go to WB.
  - SW: MemWrite=1 for this cycle only, pulse `done`, increment counter, go to IDLE.
- WB
  - RegWrite=1 for this cycle only. MemRead stays 1 for LW.
  - Pulse `done`, increment counter, go to IDLE.

Rules:
- All control outputs are registered; no combinational path from `instr_in` to any control output.
- On return to IDLE, RegWrite, MemWrite and MemRead are 0. RegDst, ALUSrc, ALUCtrl and MemtoReg are cleared to 0.
- `instr_valid` is ignored outside IDLE. Upstream holds the word until accepted.

## Timing
- Reset (`rst` high at a rising edge):
  - Next cycle: state IDLE; all controls 0, ALUCtrl=0000; `done`/`illegal` 0; `instr_count`=0; `ir_out`=0.
  - `instr_ready`=1 from the first cycle after `rst` deasserts. Handshakes are not accepted while `rst` is high.
- Reset mid-instruction aborts it:
  - No write pulse is issued after the reset edge.
  - A write pulse already asserted in that cycle is dropped on the next edge.
- Latencies, with the acceptance edge as cycle 0 (state in cycle k):
  - R-type/ADDI: DECODE 1, EXEC 2, WB 3 (RegWrite, done), IDLE 4.
  - LW: DECODE 1, EXEC 2, MEM 3 (MemRead), WB 4 (MemRead+RegWrite, done), IDLE 5.
  - SW: DECODE 1, EXEC 2, MEM 3 (MemWrite, done), IDLE 4.
  - Illegal: DECODE 1 (illegal), IDLE 2.
- Throughput: back-to-back acceptance is possible on the first IDLE cycle; there is no bubble beyond the states listed above.
- RegWrite and MemWrite are never high for more than one consecutive cycle and are never high together.
- `instr_count` increments on the `done` cycle edge; 0xFFFF wraps to 0x0000.

## Test plan
- Reset then ADD (0x012A4020):
  - `instr_ready`=1 after reset.
  - RegDst=0, ALUSrc=0, ALUCtrl=0010 from cycle 1.
  - RegWrite single pulse in cycle 3; `done` in cycle 3; `instr_count`=1.
- LW (0x8D090004) then SW (0xAD090008) back-to-back with `instr_valid` held high:
  - LW: MemRead high cycles 3–4, RegWrite only in cycle 4, MemtoReg=1, RegDst=1.
  - SW accepted in cycle 5. MemWrite only in cycle 8; RegWrite never asserted during SW.
- All six R-type functs plus ADDI: ALUCtrl equals 0010, 0110, 0000, 0001, 1100, 0111, 0010 respectively.
- Illegal instruction (opcode 0x3F, then R-type funct 0x03):
  - `illegal` pulse in cycle 1; no RegWrite/MemWrite/MemRead.
  - Back in IDLE in cycle 2; counter unchanged.
- `rst` asserted during the LW MEM state:
  - No RegWrite pulse follows; all outputs return to reset values.
  - Next instruction executes normally.
- Preload `instr_count` to 0xFFFF by issuing 65535 ADDIs, then one more ADDI: count wraps to 0x0000.
